fl2int_seq: RTL and testbench

- Multi-cycle converter from the processor's native float word {s, e, m} to a two's-complement integer of NUBITS bits.
- Float value is (-1)^s * m * 2^e: m is an unsigned MAN-bit mantissa with no hidden bit, e is a signed EXP-bit exponent.
- This is the decoding counterpart of the float ALU's normaliser. It sits between the float datapath and integer I/O ports or the integer ALU.
- Uses one bit-serial shifter instead of a wide barrel shifter, to save area on FPGA builds.

---
 rtl/fl2int_pkg.sv | 35 +++
 rtl/fl2int_shreg.sv | 50 +++++
 rtl/fl2int_seq.sv | 160 ++++++++++++++++
 tb/tb_fl2int_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fl2int_pkg.sv
// Shared definitions for the float-to-integer converter: FSM encodings,
// saturation constants and {s, e, m} field-extraction macros.
`ifndef FL2INT_PKG_SV
`define FL2INT_PKG_SV

`define FL2INT_SIGN(w, ew, mw) w[(ew)+(mw)]
`define FL2INT_EXP(w, ew, mw)  w[(ew)+(mw)-1 -: (ew)]
`define FL2INT_MAN(w, mw)      w[(mw)-1:0]

package fl2int_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_FIX   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    FSM_IDLE  = ST_IDLE,
    FSM_SHIFT = ST_SHIFT,
    FSM_FIX   = ST_FIX,
    FSM_DONE  = ST_DONE
  } fl2int_state_t;

  // Wide results; callers size-cast down to their integer width.
  function automatic logic [127:0] sat_pos(input int nb);
    return (128'd1 << (nb - 1)) - 128'd1;
  endfunction

  function automatic logic [127:0] sat_neg(input int nb);
    return 128'd1 << (nb - 1);
  endfunction

endpackage

`endif

// File: rtl/fl2int_shreg.sv
// Bidirectional one-bit-per-cycle shift accumulator with sticky left-shift
// overflow and a guard bit holding the last bit shifted out on the right.
module fl2int_shreg #(
  parameter int NUBITS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [NUBITS-1:0] load_val,
  input  logic              load_left,
  input  logic              load_ovf,
  input  logic              shift_en,
  output logic [NUBITS-1:0] acc,
  output logic              guard,
  output logic              ovf
);

  logic [NUBITS-1:0] acc_reg;
  logic              left_reg;
  logic              guard_reg;
  logic              ovf_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_reg   <= '0;
      left_reg  <= 1'b0;
      guard_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (load) begin
      acc_reg   <= load_val;
      left_reg  <= load_left;
      guard_reg <= 1'b0;
      ovf_reg   <= load_ovf;
    end else if (shift_en) begin
      if (left_reg) begin
        if (acc_reg[NUBITS-1]) ovf_reg <= 1'b1;
        acc_reg <= {acc_reg[NUBITS-2:0], 1'b0};
      end else begin
        guard_reg <= acc_reg[0];
        acc_reg   <= {1'b0, acc_reg[NUBITS-1:1]};
      end
    end
  end

  assign acc   = acc_reg;
  assign guard = guard_reg;
  // The MSB landing in the sign position after the last shift also overflows.
  assign ovf   = ovf_reg | (left_reg & acc_reg[NUBITS-1]);

endmodule

// File: rtl/fl2int_seq.sv
// Multi-cycle float {s, e, m} to two's-complement integer converter.
// Define FL2INT_ROUND_EN to round to nearest (ties away) instead of truncating.
module fl2int_seq
  import fl2int_pkg::*;
#(
  parameter int EXP    = 8,
  parameter int MAN    = 23,
  parameter int NUBITS = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MAN+EXP:0]   in_fl,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUBITS-1:0]  out_int,
  output logic               out_ovf
);

  localparam int CW = $clog2(NUBITS + 1);
  localparam logic [NUBITS-1:0] SAT_POS = NUBITS'(sat_pos(NUBITS));
  localparam logic [NUBITS-1:0] SAT_NEG = NUBITS'(sat_neg(NUBITS));

  fl2int_state_t     state_reg, state_next;
  logic [CW-1:0]     count_reg, count_next;
  logic              sign_reg, sign_next;
  logic [NUBITS-1:0] out_int_reg, out_int_next;
  logic              out_ovf_reg, out_ovf_next;

  logic                  in_s;
  logic signed [EXP-1:0] in_e;
  logic [MAN-1:0]        in_m;
  logic signed [EXP:0]   e_ext;
  logic signed [EXP:0]   neg_e;

  logic [CW-1:0]     load_k;
  logic              load_left;
  logic              load_ovf;
  logic              sh_load;
  logic              sh_shift;
  logic [NUBITS-1:0] sh_acc;
  logic              sh_guard;
  logic              sh_ovf;
  logic [NUBITS-1:0] mag;
  logic              ovf_fix;
  logic              unused_guard;

  assign in_s  = `FL2INT_SIGN(in_fl, EXP, MAN);
  assign in_e  = `FL2INT_EXP(in_fl, EXP, MAN);
  assign in_m  = `FL2INT_MAN(in_fl, MAN);
  // One extra bit so that negating the most negative exponent cannot wrap.
  assign e_ext = {in_e[EXP-1], in_e};
  assign neg_e = -e_ext;

  always_comb begin
    load_k    = '0;
    load_left = 1'b1;
    load_ovf  = 1'b0;
    if (in_m == '0) begin
      load_k = '0;
    end else if (int'(e_ext) >= NUBITS) begin
      load_ovf = 1'b1;
    end else if (!e_ext[EXP]) begin
      load_k = CW'(e_ext);
    end else begin
      load_left = 1'b0;
      if (int'(neg_e) > MAN + 1) load_k = CW'(MAN + 1);
      else                       load_k = CW'(neg_e);
    end
  end

  fl2int_shreg #(
    .NUBITS (NUBITS)
  ) u_shreg (
    .clk       (clk),
    .rst       (rst),
    .load      (sh_load),
    .load_val  ({{(NUBITS-MAN){1'b0}}, in_m}),
    .load_left (load_left),
    .load_ovf  (load_ovf),
    .shift_en  (sh_shift),
    .acc       (sh_acc),
    .guard     (sh_guard),
    .ovf       (sh_ovf)
  );

  assign unused_guard = sh_guard;

  always_comb begin
    mag     = sh_acc;
    ovf_fix = sh_ovf;
`ifdef FL2INT_ROUND_EN
    mag = sh_acc + {{(NUBITS-1){1'b0}}, sh_guard};
    if (mag[NUBITS-1]) ovf_fix = 1'b1;
`endif
  end

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    sign_next    = sign_reg;
    out_int_next = out_int_reg;
    out_ovf_next = out_ovf_reg;
    sh_load      = 1'b0;
    sh_shift     = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (state_reg)
      FSM_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sh_load    = 1'b1;
          count_next = load_k;
          sign_next  = in_s;
          state_next = FSM_SHIFT;
        end
      end
      FSM_SHIFT: begin
        if (count_reg != '0) begin
          sh_shift   = 1'b1;
          count_next = count_reg - CW'(1);
        end else begin
          state_next = FSM_FIX;
        end
      end
      FSM_FIX: begin
        out_ovf_next = ovf_fix;
        if (ovf_fix) out_int_next = sign_reg ? SAT_NEG : SAT_POS;
        else         out_int_next = sign_reg ? -mag : mag;
        state_next   = FSM_DONE;
      end
      FSM_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = FSM_IDLE;
      end
      default: state_next = FSM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= FSM_IDLE;
      count_reg   <= '0;
      sign_reg    <= 1'b0;
      out_int_reg <= '0;
      out_ovf_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      sign_reg    <= sign_next;
      out_int_reg <= out_int_next;
      out_ovf_reg <= out_ovf_next;
    end
  end

  assign out_int = out_int_reg;
  assign out_ovf = out_ovf_reg;

endmodule

// File: tb/tb_fl2int_seq.sv
// Directed self-checking bench for fl2int_seq (EXP=8, MAN=23, NUBITS=32).
module tb_fl2int_seq;

  localparam int EXP    = 8;
  localparam int MAN    = 23;
  localparam int NUBITS = 32;
`ifdef FL2INT_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  typedef struct {
    logic              s;
    int                e;
    logic [MAN-1:0]    m;
    logic [NUBITS-1:0] xi;
    logic              xo;
    int                xl;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [MAN+EXP:0]  in_fl = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [NUBITS-1:0] out_int;
  logic              out_ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fl2int_seq #(
    .EXP    (EXP),
    .MAN    (MAN),
    .NUBITS (NUBITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fl     (in_fl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_int   (out_int),
    .out_ovf   (out_ovf)
  );

  // Drives one word, counts edges from acceptance to out_valid, then consumes it.
  task automatic convert(input logic s, input int e, input logic [MAN-1:0] m,
                         output int lat, output logic [NUBITS-1:0] res, output logic ovf);
    logic [EXP-1:0] ev;
    ev = EXP'(e);
    @(negedge clk);
    in_fl    = {s, ev, m};
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
    end
    res = out_int;
    ovf = out_ovf;
    $display("conv s=%0d e=%0d m=%h -> int=%h ovf=%0d lat=%0d", s, e, m, res, ovf, lat);
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_int !== '0) begin errors++; $display("FAIL reset_out_int got=%h want=0", out_int); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got=%b want=0", out_ovf); end
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_left();
    vec_t v[4];
    int lat; logic [NUBITS-1:0] r; logic o;
    v[0] = '{1'b0, 3, 23'd5, 32'd40, 1'b0, 5};
    v[1] = '{1'b1, 4, 23'h100, 32'hFFFF_F000, 1'b0, 6};
    v[2] = '{1'b0, 8, 23'h7FFFFF, 32'h7FFF_FF00, 1'b0, 10};
    v[3] = '{1'b1, 0, 23'h7FFFFF, 32'hFF80_0001, 1'b0, 2};
    for (int i = 0; i < 4; i++) begin
      convert(v[i].s, v[i].e, v[i].m, lat, r, o);
      checks++; if (r !== v[i].xi) begin errors++; $display("FAIL left%0d_int got=%h want=%h", i, r, v[i].xi); end
      checks++; if (o !== v[i].xo) begin errors++; $display("FAIL left%0d_ovf got=%b want=%b", i, o, v[i].xo); end
      checks++; if (lat != v[i].xl) begin errors++; $display("FAIL left%0d_lat got=%0d want=%0d", i, lat, v[i].xl); end
    end
  endtask

  task automatic test_right();
    vec_t v[3];
    int lat; logic [NUBITS-1:0] r; logic o;
    v[0] = '{1'b1, -1, 23'd7, (RND ? 32'hFFFF_FFFC : 32'hFFFF_FFFD), 1'b0, 3};
    v[1] = '{1'b0, -2, 23'd6, (RND ? 32'd2 : 32'd1), 1'b0, 4};
    v[2] = '{1'b1, -3, 23'd20, (RND ? 32'hFFFF_FFFD : 32'hFFFF_FFFE), 1'b0, 5};
    for (int i = 0; i < 3; i++) begin
      convert(v[i].s, v[i].e, v[i].m, lat, r, o);
      checks++; if (r !== v[i].xi) begin errors++; $display("FAIL right%0d_int got=%h want=%h", i, r, v[i].xi); end
      checks++; if (o !== v[i].xo) begin errors++; $display("FAIL right%0d_ovf got=%b want=%b", i, o, v[i].xo); end
      checks++; if (lat != v[i].xl) begin errors++; $display("FAIL right%0d_lat got=%0d want=%0d", i, lat, v[i].xl); end
    end
  endtask

  task automatic test_zero();
    vec_t v[4];
    int lat; logic [NUBITS-1:0] r; logic o;
    v[0] = '{1'b0, -128, 23'd0, 32'd0, 1'b0, 2};
    v[1] = '{1'b1, 5, 23'd0, 32'd0, 1'b0, 2};
    v[2] = '{1'b0, -30, 23'h7FFFFF, 32'd0, 1'b0, 26};
    v[3] = '{1'b1, -128, 23'd1, 32'd0, 1'b0, 26};
    for (int i = 0; i < 4; i++) begin
      convert(v[i].s, v[i].e, v[i].m, lat, r, o);
      checks++; if (r !== v[i].xi) begin errors++; $display("FAIL zero%0d_int got=%h want=%h", i, r, v[i].xi); end
      checks++; if (o !== v[i].xo) begin errors++; $display("FAIL zero%0d_ovf got=%b want=%b", i, o, v[i].xo); end
      checks++; if (lat != v[i].xl) begin errors++; $display("FAIL zero%0d_lat got=%0d want=%0d", i, lat, v[i].xl); end
    end
  endtask

  task automatic test_saturate();
    vec_t v[4];
    int lat; logic [NUBITS-1:0] r; logic o;
    v[0] = '{1'b0, 31, 23'd1, 32'h7FFF_FFFF, 1'b1, 33};
    v[1] = '{1'b1, 40, 23'd1, 32'h8000_0000, 1'b1, 2};
    v[2] = '{1'b0, 10, 23'h7FFFFF, 32'h7FFF_FFFF, 1'b1, 12};
    v[3] = '{1'b1, 127, 23'd1, 32'h8000_0000, 1'b1, 2};
    for (int i = 0; i < 4; i++) begin
      convert(v[i].s, v[i].e, v[i].m, lat, r, o);
      checks++; if (r !== v[i].xi) begin errors++; $display("FAIL sat%0d_int got=%h want=%h", i, r, v[i].xi); end
      checks++; if (o !== v[i].xo) begin errors++; $display("FAIL sat%0d_ovf got=%b want=%b", i, o, v[i].xo); end
      checks++; if (lat != v[i].xl) begin errors++; $display("FAIL sat%0d_lat got=%0d want=%0d", i, lat, v[i].xl); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    @(negedge clk);
    in_fl    = {1'b0, 8'd3, 23'd5};
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 100 && !out_valid) begin
      @(posedge clk);
      lat++;
      #1;
    end
    $display("hold start int=%h lat=%0d", out_int, lat);
    checks++; if (lat != 5) begin errors++; $display("FAIL hold_lat got=%0d want=5", lat); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_fl    = {1'b1, 8'd2, 23'd9};
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      if (out_int !== 32'd40 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_ovf !== 1'b0) bad++;
    end
    $display("hold cycles=10 bad=%0d", bad);
    checks++; if (bad != 0) begin errors++; $display("FAIL hold_stable got=%0d bad cycles want=0", bad); end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_out_valid got=%b want=0", out_valid); end
    checks++; if (out_int !== 32'd40) begin errors++; $display("FAIL release_out_int got=%h want=28", out_int); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || out_int !== 32'd40) begin
      errors++; $display("FAIL no_accept got valid=%b int=%h want valid=0 int=28", out_valid, out_int);
    end
  endtask

  task automatic test_reset_midshift();
    int lat; logic [NUBITS-1:0] r; logic o;
    @(negedge clk);
    in_fl    = {1'b0, 8'd20, 23'd1};
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    $display("mid-shift reset valid=%b ready=%b int=%h ovf=%b", out_valid, in_ready, out_int, out_ovf);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got=%b want=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready got=%b want=1", in_ready); end
    checks++; if (out_int !== '0) begin errors++; $display("FAIL abort_out_int got=%h want=0", out_int); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL abort_out_ovf got=%b want=0", out_ovf); end
    @(negedge clk) rst = 1'b1;
    convert(1'b0, 20, 23'd1, lat, r, o);
    checks++; if (r !== 32'h0010_0000) begin errors++; $display("FAIL after_abort_int got=%h want=00100000", r); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL after_abort_ovf got=%b want=0", o); end
    checks++; if (lat != 22) begin errors++; $display("FAIL after_abort_lat got=%0d want=22", lat); end
  endtask

  initial begin
    test_reset();
    test_left();
    test_right();
    test_zero();
    test_backpressure();
    test_saturate();
    test_reset_midshift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
